// File: rtl/ex_ma_pipe_reg_pkg.sv
// Shared pipeline-stage definitions: stage-register state encoding and NOP class code.
// Imported by every stage register so bubbles and state decode stay consistent.
package ex_ma_pipe_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // Instruction class presented downstream while a stage holds a bubble.
    localparam int unsigned NOP_INST_TYPE = 0;

endpackage

// File: rtl/ex_ma_pipe_reg_payload.sv
// Enable register with synchronous clear, used for the main and skid payload entries.
// Clear takes priority over load so a kill is never overwritten by a same-cycle write.
module pipe_payload_reg #(
    parameter int unsigned      W       = 8,
    parameter logic [W-1:0]     CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Payload storage: clear beats load, load beats hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_r <= CLR_VAL;
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/ex_ma_pipe_reg.sv
// EX->MA two-entry skid pipeline register with flush and saturating upstream-stall counter.
// The main entry drives the MA outputs directly and is cleared whenever the stage empties.
module ex_ma_pipe_reg
    import ex_ma_pipe_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TYPE_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] Result_In,
    input  logic [DATA_W-1:0] Inst_In,
    input  logic [DATA_W-1:0] Operand_B_In,
    input  logic [TYPE_W-1:0] Inst_Type_In,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Result_Out,
    output logic [DATA_W-1:0] Inst_Out,
    output logic [DATA_W-1:0] Operand_B_Out,
    output logic [TYPE_W-1:0] Inst_Type_Out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned PAY_W = 3 * DATA_W + TYPE_W;
    localparam logic [PAY_W-1:0] PAY_CLR = {{(3 * DATA_W){1'b0}}, TYPE_W'(NOP_INST_TYPE)};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    pipe_state_e      state_r;
    pipe_state_e      state_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             main_ld_s;
    logic             main_clr_s;
    logic             main_src_skid_s;
    logic             skid_ld_s;
    logic             skid_clr_s;
    logic [PAY_W-1:0] in_pay_s;
    logic [PAY_W-1:0] main_d_s;
    logic [PAY_W-1:0] main_q_s;
    logic [PAY_W-1:0] skid_q_s;

    assign in_xfer_s  = in_valid & in_ready_r;
    assign out_xfer_s = out_valid_r & out_ready;
    assign in_pay_s   = {Result_In, Inst_In, Operand_B_In, Inst_Type_In};

    // Next-state and entry load/clear decode; rst and flush both kill everything held.
    always_comb begin
        state_nxt_s     = state_r;
        main_ld_s       = 1'b0;
        main_clr_s      = 1'b0;
        main_src_skid_s = 1'b0;
        skid_ld_s       = 1'b0;
        skid_clr_s      = 1'b0;
        if (rst || flush) begin
            state_nxt_s = ST_EMPTY;
            main_clr_s  = 1'b1;
            skid_clr_s  = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_nxt_s = ST_FULL;
                        main_ld_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_xfer_s && out_xfer_s) begin
                        state_nxt_s = ST_FULL;
                        main_ld_s   = 1'b1;
                    end else if (in_xfer_s) begin
                        state_nxt_s = ST_SKID;
                        skid_ld_s   = 1'b1;
                    end else if (out_xfer_s) begin
                        // Clearing main on drain keeps the bubble outputs at NOP.
                        state_nxt_s = ST_EMPTY;
                        main_clr_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (out_xfer_s) begin
                        state_nxt_s     = ST_FULL;
                        main_ld_s       = 1'b1;
                        main_src_skid_s = 1'b1;
                        skid_clr_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_SKID;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    main_clr_s  = 1'b1;
                    skid_clr_s  = 1'b1;
                end
            endcase
        end
    end

    assign main_d_s = main_src_skid_s ? skid_q_s : in_pay_s;

    // State plus registered handshake flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_SKID);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    // Saturating count of cycles the EX stage is held off; flush leaves it intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (in_valid && !in_ready_r && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    pipe_payload_reg #(
        .W       (PAY_W),
        .CLR_VAL (PAY_CLR)
    ) u_main (
        .clk (clk),
        .clr (main_clr_s),
        .en  (main_ld_s),
        .d   (main_d_s),
        .q   (main_q_s)
    );

    pipe_payload_reg #(
        .W       (PAY_W),
        .CLR_VAL (PAY_CLR)
    ) u_skid (
        .clk (clk),
        .clr (skid_clr_s),
        .en  (skid_ld_s),
        .d   (in_pay_s),
        .q   (skid_q_s)
    );

    assign {Result_Out, Inst_Out, Operand_B_Out, Inst_Type_Out} = main_q_s;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: doc/ex_ma_pipe_reg.md
EX_MA_PIPE_REG -- requirements
Module: ex_ma_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of Result, Inst and Operand_B payload fields.
REQ-002 Parameter TYPE_W, default 5, width of Inst_Type field.
REQ-003 Parameter CNT_W, default 16, width of stall counter.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  kill all held entries (branch redirect).
REQ-007 in_valid  input  1  EX stage presents a valid instruction.
REQ-008 in_ready  output  1  stage can accept this cycle.
REQ-009 Result_In, Inst_In, Operand_B_In  input  DATA_W each  EX payload.
REQ-010 Inst_Type_In  input  TYPE_W  instruction class code.
REQ-011 out_valid  output  1  MA-side entry valid.
REQ-012 out_ready  input  1  MA stage accepts this cycle.
REQ-013 Result_Out, Inst_Out, Operand_B_Out  output  DATA_W each  MA payload.
REQ-014 Inst_Type_Out  output  TYPE_W  MA instruction class.
REQ-015 stall_cnt  output  CNT_W  saturating count of upstream-stall cycles.

Function
REQ-016 Block SHALL be a two-entry skid register: main entry drives outputs, skid entry holds one overflow beat.
REQ-017 States SHALL be EMPTY (no entry), FULL (main only), SKID (main+skid).
REQ-018 in_ready SHALL be a registered signal, 1 in EMPTY and FULL, 0 in SKID.
REQ-019 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-020 EMPTY: in -> FULL, payload into main; else stay.
REQ-021 FULL: in & out -> FULL, main replaced by new payload; in & !out -> SKID, payload into skid; !in & out -> EMPTY; neither -> stay.
REQ-022 SKID: out -> FULL, skid moves to main; else stay (input is not accepted).
REQ-023 Latency in -> out_valid SHALL be 1 cycle; sustained throughput 1 beat/cycle when out_ready stays high.
REQ-024 Beats SHALL emerge in acceptance order; none duplicated or lost except by flush.
REQ-025 out_valid SHALL be 1 exactly in FULL and SKID.
REQ-026 While out_valid=0, all payload outputs SHALL be 0 (bubble = NOP, Inst_Type 0).
REQ-027 While out_valid=1 and out_ready=0, payload outputs SHALL hold stable.
REQ-028 flush SHALL force next state EMPTY, discard main and skid, and drop any beat offered the same cycle; flush overrides in/out transfers.
REQ-029 The cycle after flush, in_ready SHALL be 1 and out_valid 0.
REQ-030 stall_cnt SHALL increment each cycle in_valid=1 and in_ready=0, saturating at 2^CNT_W-1; flush does not clear it.

Reset
REQ-031 rst SHALL take priority over flush and all transfers.
REQ-032 On rst: state EMPTY, in_ready 1, out_valid 0, all payload outputs 0, skid contents 0, stall_cnt 0.
REQ-033 rst asserted mid-operation SHALL discard held beats identically to flush, and also clear stall_cnt.

Structure
REQ-034 State encoding (EMPTY/FULL/SKID) and the NOP Inst_Type value (0) SHALL live in the shared pipeline package, reused by other stage registers.
REQ-035 One sub-module, pipe_payload_reg (DATA_W*3+TYPE_W wide enable register with synchronous clear), SHALL be instantiated twice, for main and skid.

Verification
REQ-036 Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=1, stall_cnt=0.
REQ-037 Streaming: 8 beats Result_In=1..8, out_ready=1 -> Result_Out=1..8 on consecutive cycles, starting 1 cycle after first acceptance.
REQ-038 Backpressure: out_ready=0 while beats A=0x11, B=0x22, C=0x33 offered -> A,B accepted, in_ready=0 from the cycle after B, C held upstream; release out_ready -> A,B,C in order; stall_cnt increments once per blocked cycle.
REQ-039 Flush: in SKID state with flush=1 and in_valid=1 -> next cycle out_valid=0, Inst_Type_Out=0, in_ready=1; the offered beat never appears.
REQ-040 Saturation: CNT_W=4, hold in_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-041 Simultaneous: FULL with in & out in same cycle -> state stays FULL, Result_Out updates to new beat next cycle, no skid use.
